// File: rtl/branch_resolve_ctrl.sv
// Execute-stage branch/jump resolver: latches one control-transfer request, waits for
// forwarded operands, resolves direction/target, and pulses a result plus fetch redirect.
module branch_resolve_ctrl #(
  parameter int XLEN         = 32,
  parameter int CNT_W        = 16,
  parameter int ALU_OP_WIDTH = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    kill,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic [XLEN-1:0]         req_pc,
  input  logic [XLEN-1:0]         req_imm,
  input  logic [ALU_OP_WIDTH-1:0] req_br_op,
  input  logic                    req_is_jal,
  input  logic                    req_is_jalr,
  input  logic                    req_pred_taken,
  input  logic [XLEN-1:0]         req_pred_target,
  input  logic                    ops_valid,
  input  logic [XLEN-1:0]         op_a,
  input  logic [XLEN-1:0]         op_b,
  output logic                    res_valid,
  output logic                    res_taken,
  output logic [XLEN-1:0]         res_link,
  output logic                    redirect_valid,
  output logic [XLEN-1:0]         redirect_pc,
  output logic [CNT_W-1:0]        branch_cnt,
  output logic [CNT_W-1:0]        mispredict_cnt
);

  localparam logic [ALU_OP_WIDTH-1:0] ALU_OP_SEQ  = ALU_OP_WIDTH'(0);
  localparam logic [ALU_OP_WIDTH-1:0] ALU_OP_SNE  = ALU_OP_WIDTH'(1);
  localparam logic [ALU_OP_WIDTH-1:0] ALU_OP_SLT  = ALU_OP_WIDTH'(2);
  localparam logic [ALU_OP_WIDTH-1:0] ALU_OP_SLTU = ALU_OP_WIDTH'(3);
  localparam logic [ALU_OP_WIDTH-1:0] ALU_OP_SGE  = ALU_OP_WIDTH'(4);
  localparam logic [ALU_OP_WIDTH-1:0] ALU_OP_SGEU = ALU_OP_WIDTH'(5);

  typedef struct packed {
    logic [XLEN-1:0]         pc;
    logic [XLEN-1:0]         imm;
    logic [ALU_OP_WIDTH-1:0] br_op;
    logic                    is_jal;
    logic                    is_jalr;
    logic                    pred_taken;
    logic [XLEN-1:0]         pred_target;
  } req_t;

  typedef enum logic [1:0] {IDLE, WAIT_OPS, RESOLVE, DONE} state_t;

  state_t          state;
  req_t            req_q;
  logic [XLEN-1:0] a_q, b_q;
  logic            taken_q, mp_q;
  logic [XLEN-1:0] link_q, npc_q;

  logic            cond, taken, mispredict;
  logic [XLEN-1:0] jalr_sum, target, link, next_pc;

  // Resolution works only off latched state, so nothing from req_* reaches outputs.
  always_comb begin
    cond = 1'b0;
    case (req_q.br_op)
      ALU_OP_SEQ:  cond = (a_q == b_q);
      ALU_OP_SNE:  cond = (a_q != b_q);
      ALU_OP_SLT:  cond = ($signed(a_q) < $signed(b_q));
      ALU_OP_SLTU: cond = (a_q < b_q);
      ALU_OP_SGE:  cond = ($signed(a_q) >= $signed(b_q));
      ALU_OP_SGEU: cond = (a_q >= b_q);
      default:     cond = 1'b0;
    endcase
  end

  assign taken      = req_q.is_jal | req_q.is_jalr | cond;
  assign jalr_sum   = a_q + req_q.imm;
  assign target     = req_q.is_jalr ? {jalr_sum[XLEN-1:1], 1'b0} : (req_q.pc + req_q.imm);
  assign link       = req_q.pc + XLEN'(4);
  assign next_pc    = taken ? target : link;
  assign mispredict = (taken != req_q.pred_taken) |
                      (taken & req_q.pred_taken & (target != req_q.pred_target));

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      req_q          <= '0;
      a_q            <= '0;
      b_q            <= '0;
      taken_q        <= 1'b0;
      mp_q           <= 1'b0;
      link_q         <= '0;
      npc_q          <= '0;
      branch_cnt     <= '0;
      mispredict_cnt <= '0;
    end else if (kill) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE: if (req_valid) begin
          req_q <= '{pc: req_pc, imm: req_imm, br_op: req_br_op, is_jal: req_is_jal,
                     is_jalr: req_is_jalr, pred_taken: req_pred_taken,
                     pred_target: req_pred_target};
          if (ops_valid) begin
            a_q   <= op_a;
            b_q   <= op_b;
            state <= RESOLVE;
          end else begin
            state <= WAIT_OPS;
          end
        end
        WAIT_OPS: if (ops_valid) begin
          a_q   <= op_a;
          b_q   <= op_b;
          state <= RESOLVE;
        end
        RESOLVE: begin
          taken_q <= taken;
          mp_q    <= mispredict;
          link_q  <= link;
          npc_q   <= next_pc;
          state   <= DONE;
        end
        DONE: begin
          branch_cnt <= branch_cnt + CNT_W'(1);
          if (mp_q && (mispredict_cnt != '1)) mispredict_cnt <= mispredict_cnt + CNT_W'(1);
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // A flush landing in DONE swallows the pulse; result data just holds.
  assign req_ready      = (state == IDLE);
  assign res_valid      = (state == DONE) & ~kill;
  assign redirect_valid = res_valid & mp_q;
  assign res_taken      = taken_q;
  assign res_link       = link_q;
  assign redirect_pc    = npc_q;

endmodule

// File: tb/tb_branch_resolve_ctrl.sv
// Directed bench for branch_resolve_ctrl with a result scoreboard; uses a 4-bit counter
// build so wrap and saturation are reachable quickly.
module tb_branch_resolve_ctrl;
  localparam int XLEN = 32;
  localparam int CNT_W = 4;
  localparam logic [3:0] SEQ = 4'd0, SNE = 4'd1, SLT = 4'd2, SLTU = 4'd3,
                         SGE = 4'd4, SGEU = 4'd5, BAD = 4'hF;

  logic clk = 1'b0;
  logic rst, kill, req_valid, req_ready, req_is_jal, req_is_jalr, req_pred_taken;
  logic [XLEN-1:0] req_pc, req_imm, req_pred_target, op_a, op_b, res_link, redirect_pc;
  logic [3:0] req_br_op;
  logic ops_valid, res_valid, res_taken, redirect_valid;
  logic [CNT_W-1:0] branch_cnt, mispredict_cnt;

  always #5 clk = ~clk;

  branch_resolve_ctrl #(.XLEN(XLEN), .CNT_W(CNT_W), .ALU_OP_WIDTH(4)) dut (
    .clk(clk), .rst(rst), .kill(kill), .req_valid(req_valid), .req_ready(req_ready),
    .req_pc(req_pc), .req_imm(req_imm), .req_br_op(req_br_op), .req_is_jal(req_is_jal),
    .req_is_jalr(req_is_jalr), .req_pred_taken(req_pred_taken),
    .req_pred_target(req_pred_target), .ops_valid(ops_valid), .op_a(op_a), .op_b(op_b),
    .res_valid(res_valid), .res_taken(res_taken), .res_link(res_link),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .branch_cnt(branch_cnt), .mispredict_cnt(mispredict_cnt)
  );

  typedef struct packed {
    logic            taken;
    logic [XLEN-1:0] link;
    logic            rv;
    logic [XLEN-1:0] rpc;
  } exp_t;

  exp_t sbq[$];
  int n_chk = 0, n_fail = 0;
  logic [CNT_W-1:0] bcnt_m = '0, mcnt_m = '0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input logic [31:0] pc, imm, input logic [3:0] op,
                                 input logic jal, jalr, pt, input logic [31:0] ptgt, a, b);
    exp_t e;
    logic c, tk;
    logic [31:0] tgt, sum;
    case (op)
      SEQ:     c = (a == b);
      SNE:     c = (a != b);
      SLT:     c = ($signed(a) < $signed(b));
      SLTU:    c = (a < b);
      SGE:     c = ($signed(a) >= $signed(b));
      SGEU:    c = (a >= b);
      default: c = 1'b0;
    endcase
    tk  = jal | jalr | c;
    sum = a + imm;
    tgt = jalr ? (sum & 32'hFFFF_FFFE) : (pc + imm);
    e.taken = tk;
    e.link  = pc + 32'd4;
    e.rpc   = tk ? tgt : (pc + 32'd4);
    e.rv    = (tk != pt) || (tk && pt && (tgt != ptgt));
    return e;
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (!rst && res_valid) begin
      if (sbq.size() == 0) check("unexpected_res_valid", 64'd1, 64'd0);
      else begin
        e = sbq.pop_front();
        check("res_taken", 64'(res_taken), 64'(e.taken));
        check("res_link", 64'(res_link), 64'(e.link));
        check("redirect_valid", 64'(redirect_valid), 64'(e.rv));
        check("redirect_pc", 64'(redirect_pc), 64'(e.rpc));
      end
    end
  end

  task automatic drive(input logic [31:0] pc, imm, input logic [3:0] op,
                       input logic jal, jalr, pt, input logic [31:0] ptgt, a, b,
                       input logic ov);
    req_valid = 1'b1; req_pc = pc; req_imm = imm; req_br_op = op; req_is_jal = jal;
    req_is_jalr = jalr; req_pred_taken = pt; req_pred_target = ptgt;
    ops_valid = ov; op_a = ov ? a : $urandom; op_b = ov ? b : $urandom;
  endtask

  task automatic idle_inputs();
    req_valid = 1'b0; ops_valid = 1'b0; req_pc = $urandom; req_imm = $urandom;
    req_br_op = 4'($urandom); req_pred_target = $urandom; op_a = $urandom; op_b = $urandom;
  endtask

  // d = number of cycles (acceptance cycle included) with ops_valid low
  task automatic do_req(input logic [31:0] pc, imm, input logic [3:0] op,
                        input logic jal, jalr, pt, input logic [31:0] ptgt, a, b,
                        input int d);
    exp_t e;
    int lat;
    bit seen;
    e = model(pc, imm, op, jal, jalr, pt, ptgt, a, b);
    sbq.push_back(e);
    @(posedge clk); #1;
    drive(pc, imm, op, jal, jalr, pt, ptgt, a, b, d == 0);
    @(negedge clk) check("ready_idle", 64'(req_ready), 64'd1);
    @(posedge clk); lat = 1; #1;
    idle_inputs();
    for (int k = 1; k <= d; k++) begin
      if (k == d) begin ops_valid = 1'b1; op_a = a; op_b = b; end
      @(negedge clk) check("ready_wait_ops", 64'(req_ready), 64'd0);
      @(posedge clk); lat++; #1;
      ops_valid = 1'b0; op_a = $urandom; op_b = $urandom;
    end
    seen = 0;
    for (int t = 0; t < 8 && !seen; t++) begin
      @(negedge clk);
      if (res_valid) seen = 1;
      else begin @(posedge clk); lat++; end
    end
    check("res_seen", 64'(seen), 64'd1);
    if (!seen) void'(sbq.pop_back());
    check("latency", 64'(lat), 64'(2 + d));
    check("ready_done", 64'(req_ready), 64'd0);
    bcnt_m = bcnt_m + 1'b1;
    if (e.rv && mcnt_m != '1) mcnt_m = mcnt_m + 1'b1;
    @(posedge clk); @(negedge clk);
    check("branch_cnt", 64'(branch_cnt), 64'(bcnt_m));
    check("mispredict_cnt", 64'(mispredict_cnt), 64'(mcnt_m));
    check("ready_after", 64'(req_ready), 64'd1);
    check("res_valid_after", 64'(res_valid), 64'd0);
  endtask

  task automatic quiet(input int n);
    for (int i = 0; i < n; i++) @(posedge clk);
    #1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; kill = 1'b0; req_is_jal = 1'b0; req_is_jalr = 1'b0; req_pred_taken = 1'b0;
    idle_inputs();
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_ready", 64'(req_ready), 64'd1);
    check("rst_res_valid", 64'(res_valid), 64'd0);
    check("rst_res_taken", 64'(res_taken), 64'd0);
    check("rst_res_link", 64'(res_link), 64'd0);
    check("rst_redirect_valid", 64'(redirect_valid), 64'd0);
    check("rst_redirect_pc", 64'(redirect_pc), 64'd0);
    check("rst_branch_cnt", 64'(branch_cnt), 64'd0);
    check("rst_mispredict_cnt", 64'(mispredict_cnt), 64'd0);

    // BEQ taken, correctly predicted
    do_req(32'h100, 32'h20, SEQ, 0, 0, 1, 32'h120, 32'd5, 32'd5, 0);
    check("beq_branch_cnt", 64'(branch_cnt), 64'd1);
    // BLT 1 < -1 false -> mispredict to pc+4
    do_req(32'h200, 32'h40, SLT, 0, 0, 1, 32'h240, 32'h1, 32'hFFFF_FFFF, 0);
    check("blt_mispredict_cnt", 64'(mispredict_cnt), 64'd1);
    // SLTU same operands: taken, correct target
    do_req(32'h200, 32'h40, SLTU, 0, 0, 1, 32'h240, 32'h1, 32'hFFFF_FFFF, 0);
    // JALR odd sum, 3 cycles of late operands
    do_req(32'h300, 32'h2, SEQ, 0, 1, 1, 32'h1000, 32'h1001, 32'h0, 3);
    // JALR with correct prediction
    do_req(32'h300, 32'h2, SNE, 0, 1, 1, 32'h1002, 32'h1001, 32'h0, 2);
    // JAL backwards, predicted not-taken; br_op would be false
    do_req(32'h400, 32'hFFFF_FFF8, SNE, 1, 0, 0, 32'h0, 32'h7, 32'h7, 0);
    do_req(32'h500, 32'h10, SNE, 0, 0, 0, 32'h0, 32'h3, 32'h4, 1);
    do_req(32'h600, 32'h10, SGE, 0, 0, 0, 32'h0, 32'hFFFF_FFFF, 32'h1, 0);
    do_req(32'h700, 32'h10, SGEU, 0, 0, 0, 32'h0, 32'hFFFF_FFFF, 32'h1, 1);
    // taken with wrong predicted target
    do_req(32'h800, 32'h80, SEQ, 0, 0, 1, 32'h884, 32'h9, 32'h9, 0);
    // pc+4 wraps to 0
    do_req(32'hFFFF_FFFC, 32'h8, SNE, 0, 0, 1, 32'h4, 32'h2, 32'h2, 0);
    // unknown br_op resolves not-taken even with equal operands
    do_req(32'h900, 32'h10, BAD, 0, 0, 1, 32'h910, 32'h5, 32'h5, 0);

    // kill in WAIT_OPS
    @(posedge clk); #1;
    drive(32'hA00, 32'h10, SEQ, 0, 0, 0, 32'h0, 32'h1, 32'h1, 1'b0);
    @(posedge clk); #1; idle_inputs(); kill = 1'b1;
    @(posedge clk); #1; kill = 1'b0; ops_valid = 1'b1;
    @(negedge clk);
    check("kill_wait_ready", 64'(req_ready), 64'd1);
    quiet(5);
    check("kill_wait_branch_cnt", 64'(branch_cnt), 64'(bcnt_m));
    check("kill_wait_mispredict_cnt", 64'(mispredict_cnt), 64'(mcnt_m));
    ops_valid = 1'b0;

    // kill in DONE on a would-be mispredict
    drive(32'hB00, 32'h10, SEQ, 0, 0, 0, 32'h0, 32'h1, 32'h1, 1'b1);
    @(posedge clk); #1; idle_inputs();
    @(posedge clk); #1; kill = 1'b1;
    @(negedge clk);
    check("kill_done_res_valid", 64'(res_valid), 64'd0);
    check("kill_done_redirect_valid", 64'(redirect_valid), 64'd0);
    @(posedge clk); #1; kill = 1'b0;
    @(negedge clk);
    check("kill_done_ready", 64'(req_ready), 64'd1);
    check("kill_done_branch_cnt", 64'(branch_cnt), 64'(bcnt_m));
    check("kill_done_mispredict_cnt", 64'(mispredict_cnt), 64'(mcnt_m));

    // request together with kill in IDLE is dropped
    @(posedge clk); #1;
    drive(32'hC00, 32'h10, SEQ, 0, 0, 0, 32'h0, 32'h1, 32'h1, 1'b1); kill = 1'b1;
    @(posedge clk); #1; idle_inputs(); kill = 1'b0;
    @(negedge clk);
    check("kill_idle_ready", 64'(req_ready), 64'd1);
    quiet(4);
    check("kill_idle_branch_cnt", 64'(branch_cnt), 64'(bcnt_m));

    // reset while in RESOLVE
    drive(32'hD00, 32'h10, SEQ, 0, 0, 0, 32'h0, 32'h1, 32'h1, 1'b1);
    @(posedge clk); #1; idle_inputs(); rst = 1'b1;
    @(posedge clk); #1; rst = 1'b0;
    @(negedge clk);
    check("midrst_ready", 64'(req_ready), 64'd1);
    check("midrst_res_taken", 64'(res_taken), 64'd0);
    check("midrst_res_link", 64'(res_link), 64'd0);
    check("midrst_redirect_pc", 64'(redirect_pc), 64'd0);
    check("midrst_branch_cnt", 64'(branch_cnt), 64'd0);
    check("midrst_mispredict_cnt", 64'(mispredict_cnt), 64'd0);
    bcnt_m = '0; mcnt_m = '0;
    quiet(3);

    // 2^CNT_W + 1 mispredicts: branch_cnt wraps to 1, mispredict_cnt saturates
    for (int i = 0; i < (1 << CNT_W) + 1; i++)
      do_req(32'h1000 + 32'(i * 16), 32'h40, SNE, 0, 0, 1, 32'h0, 32'(i), 32'(i), i % 2);
    check("wrap_branch_cnt", 64'(branch_cnt), 64'd1);
    check("sat_mispredict_cnt", 64'(mispredict_cnt), 64'hF);
    check("sb_empty", 64'(sbq.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
